clk_div_ctrl: RTL and testbench

Run/stop and configuration controller for the programmable clock divider datapath: a free-running counter and a toggle flip-flop on the output clock.
- Starts and stops the divided clock without glitches or runt pulses.
- Accepts a new half-period value over a valid/ready handshake.
- Applies that value only at a safe period boundary (the falling edge of o_clk).
- Emits a single-cycle tick on every rising edge of o_clk, for use as a clock-enable by downstream logic.

---
 rtl/clk_div_ctrl_if.sv | 12 +
 rtl/clk_div_ctrl.sv | 113 +++++++++++
 tb/tb_clk_div_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/clk_div_ctrl_if.sv
// Configuration handshake bundle for clk_div_ctrl: a half-period value
// offered with valid/ready.
interface clk_div_ctrl_if #(
  parameter int unsigned CNT_W = 24
);
  logic             i_cfg_valid;
  logic [CNT_W-1:0] i_cfg_half;
  logic             o_cfg_ready;

  modport master (output i_cfg_valid, output i_cfg_half, input  o_cfg_ready);
  modport slave  (input  i_cfg_valid, input  i_cfg_half, output o_cfg_ready);
endinterface

// File: rtl/clk_div_ctrl.sv
// Run/stop and configuration controller for a programmable clock divider.
// New half-period values take effect only on the falling edge of o_clk.
module clk_div_ctrl #(
  parameter int unsigned CNT_W        = 24,
  parameter int unsigned DEFAULT_HALF = 12499999
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  clk_div_ctrl_if.slave    cfg,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_cur_half
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] cur_half_q, cur_half_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] pend_val_q, pend_val_d;

  logic at_top;
  logic hs;

  assign at_top = (cnt_q == cur_half_q);
  assign hs     = cfg.i_cfg_valid & ~pend_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
      cur_half_q <= CNT_W'(DEFAULT_HALF);
      pend_q     <= 1'b0;
      pend_val_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      cur_half_q <= cur_half_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
    end
  end

  // A high phase always runs to completion; only a low phase may be cut short.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (i_en) state_d = RUN;
      RUN:      if (!i_en) state_d = (!clk_q || at_top) ? IDLE : STOPPING;
      STOPPING: if (at_top) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    clk_d      = clk_q;
    tick_d     = 1'b0;
    cur_half_d = cur_half_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
      clk_d = 1'b0;
      if (hs) cur_half_d = cfg.i_cfg_half;
    end else if (state_d == IDLE && !clk_q) begin
      // Stop during the low phase: any offered or pending value lands on entry to IDLE.
      cnt_d      = '0;
      clk_d      = 1'b0;
      pend_d     = 1'b0;
      cur_half_d = hs ? cfg.i_cfg_half : (pend_q ? pend_val_q : cur_half_q);
    end else begin
      if (hs) begin
        pend_d     = 1'b1;
        pend_val_d = cfg.i_cfg_half;
      end
      if (at_top) begin
        cnt_d  = '0;
        clk_d  = ~clk_q;
        tick_d = ~clk_q;
        if (clk_q && pend_q) begin
          cur_half_d = pend_val_q;
          pend_d     = 1'b0;
        end
        // A value captured on the final stop edge cannot wait for another boundary.
        if (clk_q && state_d == IDLE && hs) begin
          cur_half_d = cfg.i_cfg_half;
          pend_d     = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    o_clk           = clk_q;
    o_tick          = tick_q;
    o_busy          = (state_q != IDLE);
    o_cur_half      = cur_half_q;
    cfg.o_cfg_ready = ~pend_q;
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed plus random stimulus for clk_div_ctrl (CNT_W=8, DEFAULT_HALF=3),
// checked every cycle against a phase-length model of the divider.
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       d_clk, d_tick, d_busy;
  logic [7:0] d_cur;

  clk_div_ctrl_if #(.CNT_W(8)) cfg_if ();

  clk_div_ctrl #(.CNT_W(8), .DEFAULT_HALF(3)) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_en       (en),
    .cfg        (cfg_if),
    .o_clk      (d_clk),
    .o_tick     (d_tick),
    .o_busy     (d_busy),
    .o_cur_half (d_cur)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: mode 0 idle, 1 run, 2 stopping; m_left = cycles left in the current phase.
  int          m_mode = 0;
  int          m_left = 0;
  bit          m_clk  = 1'b0;
  bit          m_tick = 1'b0;
  int unsigned m_cur  = 3;
  int unsigned pendq[$];

  task automatic model_step(input bit r, input bit e, input bit v, input int unsigned h);
    bit hs;
    bit stopping;
    hs     = v && (pendq.size() == 0);
    m_tick = 1'b0;
    if (!r) begin
      m_mode = 0; m_clk = 1'b0; m_cur = 3; m_left = 0;
      pendq.delete();
    end else if (m_mode == 0) begin
      if (hs) m_cur = h;
      if (e) begin m_mode = 1; m_left = int'(m_cur) + 1; end
    end else if (m_mode == 1 && !e && !m_clk) begin
      if (hs) m_cur = h;
      else if (pendq.size() != 0) m_cur = pendq.pop_front();
      pendq.delete();
      m_mode = 0;
    end else begin
      stopping = (m_mode == 2) || !e;
      if (m_left == 1) begin
        if (m_clk) begin
          if (pendq.size() != 0) m_cur = pendq.pop_front();
          if (hs) pendq.push_back(h);
          m_clk = 1'b0;
          if (stopping) begin
            m_mode = 0;
            if (pendq.size() != 0) m_cur = pendq.pop_front();
          end
        end else begin
          if (hs) pendq.push_back(h);
          m_clk = 1'b1; m_tick = 1'b1;
        end
        m_left = int'(m_cur) + 1;
      end else begin
        if (hs) pendq.push_back(h);
        m_left--;
        if (stopping) m_mode = 2;
      end
    end
  endtask

  task automatic check();
    n_vec++;
    assert (d_clk === m_clk) else begin
      n_err++; $error("FAIL o_clk got %b exp %b t=%0t", d_clk, m_clk, $time); end
    n_vec++;
    assert (d_tick === m_tick) else begin
      n_err++; $error("FAIL o_tick got %b exp %b t=%0t", d_tick, m_tick, $time); end
    n_vec++;
    assert (d_busy === (m_mode != 0)) else begin
      n_err++; $error("FAIL o_busy got %b exp %b t=%0t", d_busy, (m_mode != 0), $time); end
    n_vec++;
    assert (cfg_if.o_cfg_ready === (pendq.size() == 0)) else begin
      n_err++; $error("FAIL o_cfg_ready got %b exp %b t=%0t", cfg_if.o_cfg_ready, (pendq.size() == 0), $time); end
    n_vec++;
    assert (d_cur === m_cur[7:0]) else begin
      n_err++; $error("FAIL o_cur_half got %0d exp %0d t=%0t", d_cur, m_cur, $time); end
  endtask

  task automatic cyc(input bit r, input bit e, input bit v, input int unsigned h);
    logic [7:0] h8;
    h8 = h[7:0];
    rst_n = r; en = e; cfg_if.i_cfg_valid = v; cfg_if.i_cfg_half = h8;
    @(posedge clk);
    model_step(r, e, v, {24'd0, h8});
    @(negedge clk);
    check();
  endtask

  task automatic run(input int n, input bit e);
    for (int i = 0; i < n; i++) cyc(1'b1, e, 1'b0, 0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_if.i_cfg_valid = 1'b0; cfg_if.i_cfg_half = '0;
    @(negedge clk);
    cyc(1'b0, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b0, 0);

    // Default N=3 run: period 8, tick every 8 cycles.
    run(24, 1'b1);

    // Handshake N=1 one cycle into a high phase.
    for (int k = 0; k < 20 && !m_tick; k++) run(1, 1'b1);
    run(1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1);
    run(16, 1'b1);

    // Back to N=3, then drop i_en one cycle into the high phase.
    cyc(1'b1, 1'b1, 1'b1, 3);
    run(20, 1'b1);
    for (int k = 0; k < 20 && !m_tick; k++) run(1, 1'b1);
    run(1, 1'b1);
    run(8, 1'b0);

    // Drop during the low phase, reassert a cycle later.
    run(3, 1'b1);
    run(1, 1'b0);
    run(14, 1'b1);

    // Idle handshake N=0, then divide by 2.
    for (int k = 0; k < 20 && m_mode != 0; k++) run(1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 0);
    run(10, 1'b1);

    // Handshake coinciding with i_en dropping in the low phase, and on a stop edge.
    cyc(1'b1, 1'b1, 1'b1, 2);
    for (int k = 0; k < 20 && m_clk; k++) run(1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 3);
    run(4, 1'b1);
    for (int k = 0; k < 20 && !m_clk; k++) run(1, 1'b1);
    for (int k = 0; k < 20 && m_left != 1; k++) run(1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1);
    run(6, 1'b1);

    // Reset mid high phase with a value pending.
    for (int k = 0; k < 20 && m_mode != 0; k++) run(1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 3);
    for (int k = 0; k < 20 && !m_tick; k++) run(1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 5);
    cyc(1'b0, 1'b1, 1'b0, 0);
    run(3, 1'b0);

    // Largest half period.
    cyc(1'b1, 1'b0, 1'b1, 255);
    run(600, 1'b1);
    run(300, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit          r, e, v;
      int unsigned h;
      r = ($urandom % 200) != 0;
      e = ($urandom % 8) != 0;
      v = ($urandom % 4) == 0;
      h = (($urandom % 50) == 0) ? 255 : $urandom_range(0, 6);
      cyc(r, e, v, h);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
